// File: rtl/imm_field_packer_pkg.sv
// Shared definitions for the LEGv8 immediate field packer: format codes,
// field geometry and the helpers used to map a signed immediate onto a field.
package imm_field_packer_pkg;

  // Instruction format, taken from base instruction bits [31:30].
  typedef enum logic [1:0] {
    FMT_B     = 2'b00,
    FMT_UNSUP = 2'b01,
    FMT_CB    = 2'b10,
    FMT_D     = 2'b11
  } fmt_e;

  // Field widths and LSB positions inside the 32-bit instruction word.
  localparam int unsigned D_W    = 9;
  localparam int unsigned D_LSB  = 12;
  localparam int unsigned CB_W   = 19;
  localparam int unsigned CB_LSB = 5;
  localparam int unsigned B_W    = 26;
  localparam int unsigned B_LSB  = 0;

  // True when imm fits in a width-bit two's complement field, i.e. all bits
  // from width-1 upward are copies of the same sign bit.
  function automatic logic imm_fits(input logic [63:0] imm, input int unsigned width);
    logic [63:0] upper;
    upper = $signed(imm) >>> (width - 1);
    return (upper == '0) || (upper == '1);
  endfunction

  // Ones over the field bits of the instruction word.
  function automatic logic [31:0] field_mask(input int unsigned width, input int unsigned lsb);
    logic [63:0] ones;
    ones = (64'd1 << width) - 64'd1;
    return ones[31:0] << lsb;
  endfunction

endpackage

// File: rtl/imm_field_packer_merge.sv
// Combinational field insert: selects the format from the base word, checks
// that the immediate fits and merges it into the field, or flags an error.
module imm_field_merge
  import imm_field_packer_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [63:0] imm,
  output logic [31:0] merged,
  output logic        error
);

  fmt_e        fmt;
  int unsigned width;
  int unsigned lsb;
  logic        supported;
  logic [31:0] mask;
  logic [31:0] field;

  // Pick field geometry, check range, then clear-and-OR the field; an
  // errored beat passes the base word through unchanged.
  always_comb begin
    fmt       = fmt_e'(instr[31:30]);
    width     = B_W;
    lsb       = B_LSB;
    supported = 1'b1;
    case (fmt)
      FMT_D:   begin width = D_W;  lsb = D_LSB;  end
      FMT_CB:  begin width = CB_W; lsb = CB_LSB; end
      FMT_B:   begin width = B_W;  lsb = B_LSB;  end
      default: supported = 1'b0;
    endcase
    mask   = field_mask(width, lsb);
    field  = (imm[31:0] << lsb) & mask;
    error  = !(supported && imm_fits(imm, width));
    merged = error ? instr : ((instr & ~mask) | field);
  end

endmodule

// File: rtl/imm_field_packer.sv
// Two-stage valid/ready pipeline that packs a signed immediate into a LEGv8
// instruction word and keeps a saturating count of errored beats delivered.
//
// Handshake: a beat moves on in_valid && in_ready at the input and on
// out_valid && out_ready at the output. S2 advances when it is empty or being
// drained; S1 accepts when it is empty or S2 advances, so in_ready depends
// combinationally on out_ready. Held data stays stable while stalled.
module imm_field_packer
  import imm_field_packer_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instruction,
  input  logic [63:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instruction,
  output logic                 out_error,
  input  logic                 err_clear,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic                 s1_valid_q, s1_valid_d;
  logic [31:0]          s1_instr_q, s1_instr_d;
  logic [63:0]          s1_imm_q,   s1_imm_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [31:0]          s2_instr_q, s2_instr_d;
  logic                 s2_err_q,   s2_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

  logic        s2_adv;
  logic [31:0] s1_merged;
  logic        s1_error;

  imm_field_merge u_merge (
    .instr  (s1_instr_q),
    .imm    (s1_imm_q),
    .merged (s1_merged),
    .error  (s1_error)
  );

  // Next-state for both stages and the error counter.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_adv;

    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s1_imm_d   = s1_imm_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    err_cnt_d  = err_cnt_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_instr_d = in_instruction;
        s1_imm_d   = in_imm;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = s1_merged;
        s2_err_d   = s1_error;
      end
    end

    // Clear takes priority over a simultaneous errored delivery.
    if (err_clear) begin
      err_cnt_d = '0;
    end else if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any beats in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_imm_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s1_imm_q   <= s1_imm_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid       = s2_valid_q;
  assign out_instruction = s2_instr_q;
  assign out_error       = s2_err_q;
  assign err_count       = err_cnt_q;

endmodule

// File: tb/tb_imm_field_packer.sv
// Bench for imm_field_packer: directed format vectors, backpressure, random
// traffic against an arithmetic reference model, mid-stream reset and
// counter saturation.
module tb_imm_field_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instruction = '0;
  logic [63:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instruction;
  logic        out_error;
  logic        err_clear = 1'b0;
  logic [15:0] err_count;

  int tests_run = 0;
  int fails = 0;
  int accept_cnt = 0;
  logic mon_en = 1'b0;
  logic [15:0] model_cnt = '0;
  logic rand_done;

  // {err, instruction, imm}
  logic [96:0] exp_q[$];

  imm_field_packer #(.ERR_CNT_W(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_imm          (in_imm),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_error       (out_error),
    .err_clear       (err_clear),
    .err_count       (err_count)
  );

  // Clock
  always #5 clock = ~clock;

  // Field geometry by format: returns 0 width for the unsupported code.
  function automatic void geom(input logic [1:0] f, output int n, output int lsb);
    n = 0; lsb = 0;
    if (f == 2'b11) begin n = 9;  lsb = 12; end
    if (f == 2'b10) begin n = 19; lsb = 5;  end
    if (f == 2'b00) begin n = 26; lsb = 0;  end
  endfunction

  // Reference: range-check with signed arithmetic, replace the field value.
  function automatic logic [32:0] model(input logic [31:0] instr, input logic [63:0] imm);
    int n, lsb;
    longint v, lo, hi, span, word, old_f, new_f;
    geom(instr[31:30], n, lsb);
    if (n == 0) return {1'b1, instr};
    v    = longint'(imm);
    span = longint'(1) << n;
    lo   = -(span / 2);
    hi   = span / 2 - 1;
    if (v < lo || v > hi) return {1'b1, instr};
    word  = longint'({32'd0, instr});
    old_f = (word / (longint'(1) << lsb)) % span;
    new_f = (v + span) % span;
    word  = word - old_f * (longint'(1) << lsb) + new_f * (longint'(1) << lsb);
    return {1'b0, word[31:0]};
  endfunction

  // Scoreboard: in-order beat check, decode-side cross-check, counter model.
  always @(negedge clock) begin
    logic [96:0] e;
    int n, lsb;
    longint f, sx;
    if (mon_en) begin
      tests_run++;
      if (err_count !== model_cnt) begin
        fails++;
        $display("FAIL err_count: got %h want %h", err_count, model_cnt);
      end
      if (reset) begin
        exp_q.delete();
        model_cnt = '0;
      end else begin
        if (out_valid && out_ready) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got %h err %b want none", out_instruction, out_error);
            e = '0;
          end else begin
            e = exp_q.pop_front();
            if (out_instruction !== e[95:64] || out_error !== e[96]) begin
              fails++;
              $display("FAIL beat: got %h err %b want %h err %b", out_instruction, out_error, e[95:64], e[96]);
            end
            if (!e[96]) begin
              tests_run++;
              geom(e[95:94], n, lsb);
              f  = longint'({32'd0, out_instruction} >> lsb) % (longint'(1) << n);
              sx = (f >= (longint'(1) << (n - 1))) ? f - (longint'(1) << n) : f;
              if (sx !== longint'(e[63:0])) begin
                fails++;
                $display("FAIL sext_crosscheck: got %0d want %0d", sx, longint'(e[63:0]));
              end
            end
          end
        end
        if (err_clear) model_cnt = '0;
        else if (out_valid && out_ready && e[96] && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      end
    end
  end

  // Driver: hold a beat until accepted, record expectation at acceptance.
  task automatic send_beat(input logic [31:0] instr, input logic [63:0] imm);
    int guard = 0;
    in_valid = 1'b1; in_instruction = instr; in_imm = imm;
    while (1) begin
      @(negedge clock);
      if (in_ready) begin
        exp_q.push_back({model(instr, imm), imm});
        accept_cnt++;
        break;
      end
      guard++;
      if (guard > 500) begin
        tests_run++; fails++;
        $display("FAIL send_timeout: got in_ready 0 want 1");
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(posedge clock); #1;
      guard++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0 || out_error !== 1'b0 || out_instruction !== 32'h0 ||
        err_count !== 16'h0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got v%b e%b i%h c%h r%b want v0 e0 i0 c0 r1",
               out_valid, out_error, out_instruction, err_count, in_ready);
    end
  endtask

  task automatic test_d_format();
    out_ready = 1'b1;
    send_beat(32'hF840_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL d_latency_early: got out_valid %b want 0", out_valid);
    end
    @(posedge clock); #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_instruction !== 32'hF85F_F000 || out_error !== 1'b0) begin
      fails++; $display("FAIL d_pack: got v%b %h e%b want v1 F85FF000 e0", out_valid, out_instruction, out_error);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_cb_format();
    send_beat(32'hB400_0000, 64'd4);
    send_beat(32'hB400_0000, -64'sd262144);
    tests_run++;
    if (out_instruction !== 32'hB400_0080 || out_error !== 1'b0) begin
      fails++; $display("FAIL cb_pos: got %h e%b want B4000080 e0", out_instruction, out_error);
    end
    @(posedge clock); #1;
    tests_run++;
    if (out_instruction !== 32'hB480_0000 || out_error !== 1'b0) begin
      fails++; $display("FAIL cb_neg: got %h e%b want B4800000 e0", out_instruction, out_error);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_b_range();
    send_beat(32'h1400_0000, 64'h0000_0000_0200_0000);
    @(posedge clock); #1;
    tests_run++;
    if (out_instruction !== 32'h1400_0000 || out_error !== 1'b1) begin
      fails++; $display("FAIL b_overflow: got %h e%b want 14000000 e1", out_instruction, out_error);
    end
    @(posedge clock); #1;
    tests_run++;
    if (err_count !== 16'd1) begin
      fails++; $display("FAIL b_err_count: got %0d want 1", err_count);
    end
    send_beat(32'h1400_0000, 64'hFFFF_FFFF_FE00_0000);
    @(posedge clock); #1;
    tests_run++;
    if (out_instruction !== 32'h1600_0000 || out_error !== 1'b0) begin
      fails++; $display("FAIL b_min: got %h e%b want 16000000 e0", out_instruction, out_error);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_unsupported_clear();
    send_beat(32'h4000_0000, 64'd0);
    @(posedge clock); #1;
    tests_run++;
    if (out_instruction !== 32'h4000_0000 || out_error !== 1'b1) begin
      fails++; $display("FAIL unsup: got %h e%b want 40000000 e1", out_instruction, out_error);
    end
    @(posedge clock); #1;
    tests_run++;
    if (err_count !== 16'd2) begin
      fails++; $display("FAIL unsup_count: got %0d want 2", err_count);
    end
    out_ready = 1'b0;
    send_beat(32'h4000_0000, 64'd0);
    @(posedge clock); #1;
    out_ready = 1'b1; err_clear = 1'b1;
    @(posedge clock); #1;
    err_clear = 1'b0;
    tests_run++;
    if (err_count !== 16'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL clear_wins: got c%0d v%b want c0 v0", err_count, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    out_ready = 1'b0;
    base = accept_cnt;
    fork
      begin
        for (int i = 0; i < 5; i++) send_beat(32'hF800_0000 | 32'(i), 64'(i) - 64'd2);
      end
      begin
        repeat (4) @(posedge clock);
        #1;
        tests_run++;
        if (accept_cnt - base != 2 || in_ready !== 1'b0) begin
          fails++; $display("FAIL bp_accept: got %0d rdy %b want 2 rdy 0", accept_cnt - base, in_ready);
        end
        out_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
          fails++; $display("FAIL bp_stream: got %0d left want 0", exp_q.size());
        end
      end
    join
  endtask

  task automatic test_random();
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [1:0] f;
          int n, lsb, sel;
          longint half, v;
          f = 2'($urandom_range(0, 3));
          geom(f, n, lsb);
          if (n == 0) n = 9;
          half = longint'(1) << (n - 1);
          sel = $urandom_range(0, 5);
          case (sel)
            0: v = longint'($urandom_range(0, 32'(2 * half - 1))) - half;
            1: v = half - 1;
            2: v = -half;
            3: v = half;
            4: v = -half - 1;
            default: v = longint'({$urandom, $urandom});
          endcase
          send_beat({f, 30'($urandom)}, 64'(v));
          if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clock); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send_beat(32'h4000_0000, 64'd0);
    send_beat(32'hB400_0000, 64'd8);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0 || err_count !== 16'd0 || out_instruction !== 32'h0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid: got v%b c%0d i%h r%b want v0 c0 i0 r1",
                        out_valid, err_count, out_instruction, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL stale_beat: got out_valid %b want 0", out_valid);
      end
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 65534; i++) send_beat(32'h4000_0000, 64'd0);
    wait_drain();
    @(posedge clock); #1;
    tests_run++;
    if (err_count !== 16'hFFFE) begin
      fails++; $display("FAIL sat_pre: got %h want FFFE", err_count);
    end
    for (int i = 0; i < 3; i++) send_beat(32'h1400_0000, 64'h0400_0000);
    wait_drain();
    @(posedge clock); #1;
    tests_run++;
    if (err_count !== 16'hFFFF) begin
      fails++; $display("FAIL sat_hold: got %h want FFFF", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_d_format();
    test_cb_format();
    test_b_range();
    test_unsupported_clear();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    test_saturation();
    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
